fwd_hazard_unit: RTL and testbench
==================================

Name: fwd_hazard_unit

Overview:
- Parametrised successor to the 5-stage forwarding unit. Resolves operand forwarding for NREAD decode-stage read ports against NSTAGE downstream producer stages.
- Adds a sequential scoreboard for one outstanding multicycle (mult/div) result, and a writeback-port arbiter.
- Generates pipeline stall and register-file write-port steering.
- Sits between decode and the register file. Drives operand muxes for the branch comparator and the EX latch.

Parameters:
- NREAD, 3, number of decode read ports (rs, rt, branch-compare).
- NSTAGE, 3, number of producer stages; index 0 = youngest (EX), NSTAGE-1 = oldest (WB).
- WIDTH, 32, data word width.
- MCLAT_W, 4, width of the multicycle latency counter; maximum latency is 2^MCLAT_W-1.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous active-high reset.
- dec_reg  in  NREAD*5  source register number per read port.
- dec_ren  in  NREAD  read port is live this cycle.
- rf_rdat  in  NREAD*WIDTH  register-file read data per port.
- stg_dest  in  NSTAGE*5  destination register per stage.
- stg_wen  in  NSTAGE  stage will write the register file.
- stg_ready  in  NSTAGE  stage result is valid this cycle (low for a load in EX).
- stg_data  in  NSTAGE*WIDTH  stage result value.
- mc_issue  in  1  multicycle op leaves EX this cycle.
- mc_dest  in  5  multicycle destination register.
- mc_lat  in  MCLAT_W  cycles until the result is valid; must be >= 1.
- mc_result  in  WIDTH  multicycle unit output; valid while in DONE.
- fwd_sel  out  NREAD*SELW  per-port source select, fwdsel_t.
- fwd_data  out  NREAD*WIDTH  resolved operand per port.
- stall  out  1  freeze fetch/decode, insert bubble into EX.
- mc_busy  out  1  multicycle unit occupied; EX must not issue another.
- rf_wsel  out  1  write port source: 0 = pipeline WB, 1 = multicycle.
- rf_wen_mc  out  1  multicycle result written this cycle.

Behaviour:
- Forward select (combinational):
  - For each port p with dec_ren[p]=1 and dec_reg[p]!=0, take the youngest stage s with stg_wen[s]=1 and stg_dest[s]==dec_reg[p]. Select FWD_STG(s), fwd_data = stg_data[s].
  - Otherwise, if the FSM is in DONE and mc_dest_q == dec_reg[p], select FWD_MC, fwd_data = mc_result.
  - Otherwise select FWD_RF, fwd_data = rf_rdat[p].
  - Register 0 is never forwarded: always FWD_RF with data 0.
- Stall (combinational), asserted when any live port matches either:
  - the youngest matching stage, which has stg_ready=0 (load-use); or
  - mc_dest_q while the FSM is in BUSY.
  - A match that is resolved by a younger ready stage does not stall.
- Multicycle FSM, states IDLE, BUSY, DONE:
  - IDLE --mc_issue--> BUSY. Latch mc_dest_q, load cnt = mc_lat-1.
  - BUSY: cnt decrements each cycle. When cnt == 0 the next state is DONE.
  - DONE: rf_wsel=1 and rf_wen_mc=1 when stg_wen[NSTAGE-1]=0, then go to IDLE. Otherwise remain in DONE; the pipeline WB has priority.
  - Back-to-back: mc_issue in DONE on the write cycle goes directly to BUSY and latches the new op. mc_issue in BUSY, or in DONE without a write, is a protocol error and is ignored; an assertion flags it.
  - mc_busy = 1 in BUSY and in DONE.
- WAW with the multicycle op: if a pipeline stage with stg_wen=1 targets mc_dest_q while in BUSY or DONE, set the drop flag. The multicycle write is then suppressed (rf_wen_mc=0) but the FSM still returns to IDLE.
- Reset: state IDLE, cnt 0, mc_dest_q 0, drop 0. Outputs stall=0, mc_busy=0, rf_wsel=0, rf_wen_mc=0, and fwd_sel=FWD_RF for all ports. RST mid-BUSY abandons the op with no write.

Optional Feature:
- FWD_STATS_EN defined:
  - Adds 32-bit saturating counters stall_cnt, fwd_cnt and mcwait_cnt.
  - stall_cnt counts stall cycles; fwd_cnt counts ports selecting non-RF this cycle; mcwait_cnt counts DONE cycles blocked by WB.
  - Counters clear on RST and are exposed as outputs stat_stall, stat_fwd and stat_mcwait.
- FWD_STATS_EN undefined: the counters and their ports are absent.

Decomposition:
- mux_types_pkg adds:
  - fwdsel_t, an enum of FWD_RF, FWD_MC and FWD_STG0..FWD_STG(NSTAGE-1); SELW = $clog2(NSTAGE+2).
  - mcstate_t, an enum of IDLE, BUSY and DONE.
- cpu_types_pkg supplies regbits_t and word_t.
- Natural sub-module: fwd_port_sel, per-port priority select plus the stall term, instantiated NREAD times via generate.
- The FSM and arbiter stay in the top level.

Test Plan:
- Port0 reads r5; EX writes r5=0xAAAA ready; WB writes r5=0x5555 -> fwd_sel0=FWD_STG0, fwd_data0=0xAAAA, stall=0.
- Load in EX to r7 (stg_ready[0]=0); port1 reads r7 -> stall=1 for one cycle. Next cycle the load is in MEM and ready -> FWD_STG1, stall=0.
- mc_issue with dest r9, mc_lat=3; decode reads r9 -> stall=1 for 3 cycles. In DONE, fwd_sel=FWD_MC and rf_wen_mc=1.
- In DONE, stg_wen[WB]=1 for 2 cycles -> rf_wen_mc stays 0 and mc_busy=1 for 2 extra cycles. Write occurs on cycle 3 with rf_wsel=1.
- mc dest r4 in BUSY while EX writes r4 -> the multicycle write is suppressed, and the FSM returns to IDLE after DONE.
- RST asserted in BUSY with cnt=2 -> next cycle IDLE, mc_busy=0, and no rf_wen_mc ever; port reads of r0 always return data 0 with FWD_RF.

Source files
------------

// File: rtl/fwd_hazard_unit_pkg.sv
// Shared types for the forwarding / hazard unit: register numbers, data words,
// forward-select encoding and multicycle scoreboard states.
package fwd_hazard_unit_pkg;

  localparam int unsigned NSTAGE_MAX = 3;
  localparam int unsigned SELW       = $clog2(NSTAGE_MAX + 2);

  typedef logic [4:0]  regbits_t;
  typedef logic [31:0] word_t;

  typedef enum logic [SELW-1:0] {
    FWD_RF   = 3'd0,
    FWD_MC   = 3'd1,
    FWD_STG0 = 3'd2,
    FWD_STG1 = 3'd3,
    FWD_STG2 = 3'd4
  } fwdsel_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } mcstate_t;

  function automatic fwdsel_t stg_sel(input int unsigned s);
    return fwdsel_t'(SELW'(s + 2));
  endfunction

endpackage

// File: rtl/fwd_hazard_unit_port_sel.sv
// Per-read-port operand source priority (youngest stage, then multicycle,
// then register file) plus the load-use / multicycle-pending stall term.
module fwd_port_sel
  import fwd_hazard_unit_pkg::*;
#(
  parameter int unsigned NSTAGE = 3,
  parameter int unsigned WIDTH  = 32
) (
  input  logic                    ren,
  input  regbits_t                rnum,
  input  logic [WIDTH-1:0]        rf_rdat,
  input  logic [NSTAGE*5-1:0]     stg_dest,
  input  logic [NSTAGE-1:0]       stg_wen,
  input  logic [NSTAGE-1:0]       stg_ready,
  input  logic [NSTAGE*WIDTH-1:0] stg_data,
  input  logic                    mc_done,
  input  logic                    mc_pend,
  input  regbits_t                mc_dest_q,
  input  logic [WIDTH-1:0]        mc_result,
  output fwdsel_t                 sel,
  output logic [WIDTH-1:0]        data,
  output logic                    stall
);

  logic hit;
  logic hit_rdy;

  always_comb begin
    sel     = FWD_RF;
    data    = rf_rdat;
    stall   = 1'b0;
    hit     = 1'b0;
    hit_rdy = 1'b1;
    if (rnum == '0) begin
      data = '0;
    end else if (ren) begin
      // Walk oldest to youngest so the youngest match overwrites earlier ones.
      for (int unsigned i = 0; i < NSTAGE; i++) begin
        if (stg_wen[NSTAGE-1-i] && (stg_dest[(NSTAGE-1-i)*5 +: 5] == rnum)) begin
          hit     = 1'b1;
          hit_rdy = stg_ready[NSTAGE-1-i];
          sel     = stg_sel(NSTAGE-1-i);
          data    = stg_data[(NSTAGE-1-i)*WIDTH +: WIDTH];
        end
      end
      if (!hit && mc_done && (mc_dest_q == rnum)) begin
        sel  = FWD_MC;
        data = mc_result;
      end
      stall = hit ? !hit_rdy : (mc_pend && (mc_dest_q == rnum));
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Decode-stage forwarding, stall generation and multicycle writeback scoreboard.
// Define FWD_STATS_EN to add saturating stall/forward/multicycle-wait counters.
module fwd_hazard_unit
  import fwd_hazard_unit_pkg::*;
#(
  parameter int unsigned NREAD   = 3,
  parameter int unsigned NSTAGE  = 3,
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned MCLAT_W = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [NREAD*5-1:0]      dec_reg,
  input  logic [NREAD-1:0]        dec_ren,
  input  logic [NREAD*WIDTH-1:0]  rf_rdat,
  input  logic [NSTAGE*5-1:0]     stg_dest,
  input  logic [NSTAGE-1:0]       stg_wen,
  input  logic [NSTAGE-1:0]       stg_ready,
  input  logic [NSTAGE*WIDTH-1:0] stg_data,
  input  logic                    mc_issue,
  input  logic [4:0]              mc_dest,
  input  logic [MCLAT_W-1:0]      mc_lat,
  input  logic [WIDTH-1:0]        mc_result,
  output logic [NREAD*SELW-1:0]   fwd_sel,
  output logic [NREAD*WIDTH-1:0]  fwd_data,
  output logic                    stall,
  output logic                    mc_busy,
  output logic                    rf_wsel,
  output logic                    rf_wen_mc
`ifdef FWD_STATS_EN
  ,
  output logic [31:0]             stat_stall,
  output logic [31:0]             stat_fwd,
  output logic [31:0]             stat_mcwait
`endif
);

  mcstate_t             state_q, state_d;
  logic [MCLAT_W-1:0]   cnt_q;
  regbits_t             mc_dest_q;
  logic                 drop_q;
  logic                 wr_slot;
  logic                 issue_ok;
  logic                 waw;
  logic [NREAD-1:0]     ren_eff;
  logic [NREAD-1:0]     port_stall;
  fwdsel_t              port_sel [NREAD];

  // Port enables are masked during reset so every port reads as FWD_RF.
  assign ren_eff = dec_ren & ~{NREAD{RST}};

  for (genvar p = 0; p < NREAD; p++) begin : g_port
    fwd_port_sel #(
      .NSTAGE (NSTAGE),
      .WIDTH  (WIDTH)
    ) u_sel (
      .ren       (ren_eff[p]),
      .rnum      (dec_reg[p*5 +: 5]),
      .rf_rdat   (rf_rdat[p*WIDTH +: WIDTH]),
      .stg_dest  (stg_dest),
      .stg_wen   (stg_wen),
      .stg_ready (stg_ready),
      .stg_data  (stg_data),
      .mc_done   (state_q == DONE),
      .mc_pend   (state_q == BUSY),
      .mc_dest_q (mc_dest_q),
      .mc_result (mc_result),
      .sel       (port_sel[p]),
      .data      (fwd_data[p*WIDTH +: WIDTH]),
      .stall     (port_stall[p])
    );
    assign fwd_sel[p*SELW +: SELW] = port_sel[p];
  end

  assign stall = |port_stall;

  always_comb begin
    wr_slot  = (state_q == DONE) && !stg_wen[NSTAGE-1];
    issue_ok = mc_issue && ((state_q == IDLE) || wr_slot);
    waw      = 1'b0;
    for (int unsigned i = 0; i < NSTAGE; i++) begin
      if (stg_wen[i] && (stg_dest[i*5 +: 5] == mc_dest_q)) waw = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (mc_issue) state_d = BUSY;
      BUSY:    if (cnt_q == '0) state_d = DONE;
      DONE:    if (wr_slot) state_d = mc_issue ? BUSY : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q     <= '0;
      mc_dest_q <= '0;
      drop_q    <= 1'b0;
    end else if (issue_ok) begin
      cnt_q     <= mc_lat - 1'b1;
      mc_dest_q <= mc_dest;
      drop_q    <= 1'b0;
    end else begin
      if ((state_q == BUSY) && (cnt_q != '0)) cnt_q <= cnt_q - 1'b1;
      if (wr_slot)                            drop_q <= 1'b0;
      else if ((state_q != IDLE) && waw)      drop_q <= 1'b1;
    end
  end

  always_comb begin
    mc_busy   = (state_q != IDLE);
    rf_wsel   = wr_slot && !RST;
    rf_wen_mc = wr_slot && !drop_q && !RST;
  end

  a_mc_proto: assert property (@(posedge CLK) disable iff (RST)
    mc_issue |-> ((state_q == IDLE) || wr_slot));
  a_mc_lat: assert property (@(posedge CLK) disable iff (RST)
    mc_issue |-> (mc_lat != '0));

`ifdef FWD_STATS_EN
  logic [31:0] fwd_now;
  logic [32:0] fwd_sum;

  always_comb begin
    fwd_now = '0;
    for (int unsigned p = 0; p < NREAD; p++) begin
      if (port_sel[p] != FWD_RF) fwd_now = fwd_now + 32'd1;
    end
    fwd_sum = {1'b0, stat_fwd} + {1'b0, fwd_now};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      stat_stall  <= '0;
      stat_fwd    <= '0;
      stat_mcwait <= '0;
    end else begin
      if (stall && (stat_stall != '1)) stat_stall <= stat_stall + 32'd1;
      stat_fwd <= fwd_sum[32] ? '1 : fwd_sum[31:0];
      if ((state_q == DONE) && stg_wen[NSTAGE-1] && (stat_mcwait != '1))
        stat_mcwait <= stat_mcwait + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: table of combinational forwarding
// vectors followed by hand-written multicycle scoreboard sequences.
module tb_fwd_hazard_unit;
  import fwd_hazard_unit_pkg::*;

  localparam int unsigned NREAD   = 3;
  localparam int unsigned NSTAGE  = 3;
  localparam int unsigned WIDTH   = 32;
  localparam int unsigned MCLAT_W = 4;

  localparam logic [95:0] RF_VAL  = {32'hC2C2C2C2, 32'hB1B1B1B1, 32'hA0A0A0A0};
  localparam logic [95:0] STG_VAL = {32'h00005555, 32'h00007777, 32'h0000AAAA};

  logic                    CLK = 1'b0;
  logic                    RST;
  logic [NREAD*5-1:0]      dec_reg;
  logic [NREAD-1:0]        dec_ren;
  logic [NREAD*WIDTH-1:0]  rf_rdat;
  logic [NSTAGE*5-1:0]     stg_dest;
  logic [NSTAGE-1:0]       stg_wen;
  logic [NSTAGE-1:0]       stg_ready;
  logic [NSTAGE*WIDTH-1:0] stg_data;
  logic                    mc_issue;
  logic [4:0]              mc_dest;
  logic [MCLAT_W-1:0]      mc_lat;
  logic [WIDTH-1:0]        mc_result;
  logic [NREAD*SELW-1:0]   fwd_sel;
  logic [NREAD*WIDTH-1:0]  fwd_data;
  logic                    stall;
  logic                    mc_busy;
  logic                    rf_wsel;
  logic                    rf_wen_mc;
`ifdef FWD_STATS_EN
  logic [31:0]             stat_stall;
  logic [31:0]             stat_fwd;
  logic [31:0]             stat_mcwait;
`endif

  fwd_hazard_unit #(
    .NREAD   (NREAD),
    .NSTAGE  (NSTAGE),
    .WIDTH   (WIDTH),
    .MCLAT_W (MCLAT_W)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .dec_reg   (dec_reg),
    .dec_ren   (dec_ren),
    .rf_rdat   (rf_rdat),
    .stg_dest  (stg_dest),
    .stg_wen   (stg_wen),
    .stg_ready (stg_ready),
    .stg_data  (stg_data),
    .mc_issue  (mc_issue),
    .mc_dest   (mc_dest),
    .mc_lat    (mc_lat),
    .mc_result (mc_result),
    .fwd_sel   (fwd_sel),
    .fwd_data  (fwd_data),
    .stall     (stall),
    .mc_busy   (mc_busy),
    .rf_wsel   (rf_wsel),
    .rf_wen_mc (rf_wen_mc)
`ifdef FWD_STATS_EN
    ,
    .stat_stall  (stat_stall),
    .stat_fwd    (stat_fwd),
    .stat_mcwait (stat_mcwait)
`endif
  );

  always #5 CLK = ~CLK;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  typedef struct {
    logic [14:0] regs;  // {port2, port1, port0}
    logic [2:0]  ren;
    logic [14:0] dest;  // {WB, MEM, EX}
    logic [2:0]  wen;
    logic [2:0]  rdy;
    logic [8:0]  sel;   // {port2, port1, port0}
    logic [95:0] data;
    logic        stl;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_stg(input logic [14:0] d, input logic [2:0] w, input logic [2:0] r);
    stg_dest  = d;
    stg_wen   = w;
    stg_ready = r;
  endtask

  task automatic clear_in();
    dec_reg  = '0;
    dec_ren  = '0;
    set_stg('0, '0, 3'b111);
    mc_issue = 1'b0;
    mc_dest  = '0;
    mc_lat   = '0;
  endtask

  function automatic logic [2:0] psel(input int unsigned p);
    return fwd_sel[p*SELW +: SELW];
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{ {5'd2, 5'd1, 5'd5}, 3'b111, {5'd5, 5'd3, 5'd5}, 3'b111, 3'b111,
                 {FWD_RF, FWD_RF, FWD_STG0}, {32'hC2C2C2C2, 32'hB1B1B1B1, 32'h0000AAAA}, 1'b0 };
    vecs[1] = '{ {5'd7, 5'd7, 5'd0}, 3'b011, {5'd0, 5'd0, 5'd7}, 3'b001, 3'b110,
                 {FWD_RF, FWD_STG0, FWD_RF}, {32'hC2C2C2C2, 32'h0000AAAA, 32'h0}, 1'b1 };
    vecs[2] = '{ {5'd7, 5'd7, 5'd0}, 3'b011, {5'd0, 5'd7, 5'd7}, 3'b010, 3'b111,
                 {FWD_RF, FWD_STG1, FWD_RF}, {32'hC2C2C2C2, 32'h00007777, 32'h0}, 1'b0 };
    vecs[3] = '{ {5'd9, 5'd4, 5'd9}, 3'b111, {5'd9, 5'd9, 5'd9}, 3'b111, 3'b101,
                 {FWD_STG0, FWD_RF, FWD_STG0}, {32'h0000AAAA, 32'hB1B1B1B1, 32'h0000AAAA}, 1'b0 };
    vecs[4] = '{ {5'd8, 5'd6, 5'd6}, 3'b101, {5'd6, 5'd8, 5'd6}, 3'b111, 3'b110,
                 {FWD_STG1, FWD_RF, FWD_STG0}, {32'h00007777, 32'hB1B1B1B1, 32'h0000AAAA}, 1'b1 };
    vecs[5] = '{ {5'd31, 5'd0, 5'd31}, 3'b111, {5'd31, 5'd2, 5'd31}, 3'b100, 3'b111,
                 {FWD_STG2, FWD_RF, FWD_STG2}, {32'h00005555, 32'h0, 32'h00005555}, 1'b0 };
    vecs[6] = '{ {5'd5, 5'd5, 5'd5}, 3'b000, {5'd5, 5'd5, 5'd5}, 3'b111, 3'b000,
                 {FWD_RF, FWD_RF, FWD_RF}, {32'hC2C2C2C2, 32'hB1B1B1B1, 32'hA0A0A0A0}, 1'b0 };
    vecs[7] = '{ {5'd0, 5'd0, 5'd0}, 3'b111, {5'd0, 5'd0, 5'd0}, 3'b111, 3'b000,
                 {FWD_RF, FWD_RF, FWD_RF}, 96'h0, 1'b0 };
    vecs[8] = '{ {5'd3, 5'd12, 5'd13}, 3'b111, {5'd3, 5'd12, 5'd14}, 3'b110, 3'b011,
                 {FWD_STG2, FWD_STG1, FWD_RF}, {32'h00005555, 32'h00007777, 32'hA0A0A0A0}, 1'b1 };

    rf_rdat   = RF_VAL;
    stg_data  = STG_VAL;
    mc_result = 32'hDEADBEEF;
    clear_in();

    // Reset with live matching hazards on every port
    RST     = 1'b1;
    dec_reg = {5'd5, 5'd5, 5'd5};
    dec_ren = 3'b111;
    set_stg({5'd5, 5'd5, 5'd5}, 3'b111, 3'b000);
    tick();
    tick();
    for (int unsigned p = 0; p < NREAD; p++) chk($sformatf("rst_sel%0d", p), psel(p), FWD_RF);
    chk("rst_stall", stall, 1'b0);
    chk("rst_busy", mc_busy, 1'b0);
    chk("rst_wsel", rf_wsel, 1'b0);
    chk("rst_wen_mc", rf_wen_mc, 1'b0);
    RST = 1'b0;
    clear_in();
    tick();

    // Combinational forwarding table (scoreboard idle)
    for (int unsigned i = 0; i < 9; i++) begin
      dec_reg = vecs[i].regs;
      dec_ren = vecs[i].ren;
      set_stg(vecs[i].dest, vecs[i].wen, vecs[i].rdy);
      #1;
      for (int unsigned p = 0; p < NREAD; p++) begin
        chk($sformatf("v%0d_sel%0d", i, p), psel(p), vecs[i].sel[p*3 +: 3]);
        chk($sformatf("v%0d_data%0d", i, p), fwd_data[p*WIDTH +: WIDTH], vecs[i].data[p*32 +: 32]);
      end
      chk($sformatf("v%0d_stall", i), stall, vecs[i].stl);
      tick();
    end
    clear_in();
    tick();

    // Multicycle r9, latency 3: three stall cycles then forward from DONE
    mc_issue = 1'b1; mc_dest = 5'd9; mc_lat = 4'd3;
    #1;
    chk("a_idle_busy", mc_busy, 1'b0);
    tick();
    mc_issue = 1'b0;
    dec_reg  = {5'd0, 5'd0, 5'd9};
    dec_ren  = 3'b001;
    for (int unsigned k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("a_stall_c%0d", k), stall, 1'b1);
      chk($sformatf("a_busy_c%0d", k), mc_busy, 1'b1);
      chk($sformatf("a_nowen_c%0d", k), rf_wen_mc, 1'b0);
      tick();
    end
    #1;
    chk("a_done_sel", psel(0), FWD_MC);
    chk("a_done_data", fwd_data[31:0], 32'hDEADBEEF);
    chk("a_done_stall", stall, 1'b0);
    chk("a_done_wen", rf_wen_mc, 1'b1);
    chk("a_done_wsel", rf_wsel, 1'b1);
    tick();
    #1;
    chk("a_idle_again", mc_busy, 1'b0);
    chk("a_idle_sel", psel(0), FWD_RF);
    chk("a_idle_data", fwd_data[31:0], 32'hA0A0A0A0);
    clear_in();
    tick();

    // WB holds the write port for two DONE cycles
    mc_issue = 1'b1; mc_dest = 5'd10; mc_lat = 4'd1;
    tick();
    mc_issue = 1'b0;
    set_stg({5'd11, 5'd0, 5'd0}, 3'b100, 3'b111);
    #1;
    chk("b_busy", mc_busy, 1'b1);
    tick();
    for (int unsigned k = 0; k < 2; k++) begin
      #1;
      chk($sformatf("b_blk_wen%0d", k), rf_wen_mc, 1'b0);
      chk($sformatf("b_blk_wsel%0d", k), rf_wsel, 1'b0);
      chk($sformatf("b_blk_busy%0d", k), mc_busy, 1'b1);
      tick();
    end
    set_stg('0, 3'b000, 3'b111);
    #1;
    chk("b_wr_wen", rf_wen_mc, 1'b1);
    chk("b_wr_wsel", rf_wsel, 1'b1);
    tick();
    #1;
    chk("b_idle", mc_busy, 1'b0);
    clear_in();
    tick();

    // WAW: EX writes r4 while multicycle r4 is BUSY
    mc_issue = 1'b1; mc_dest = 5'd4; mc_lat = 4'd2;
    tick();
    mc_issue = 1'b0;
    dec_reg  = {5'd0, 5'd0, 5'd4};
    dec_ren  = 3'b001;
    set_stg({5'd0, 5'd0, 5'd4}, 3'b001, 3'b111);
    #1;
    chk("c_ex_resolves_stall", stall, 1'b0);
    chk("c_ex_sel", psel(0), FWD_STG0);
    tick();
    clear_in();
    #1;
    chk("c_busy", mc_busy, 1'b1);
    tick();
    #1;
    chk("c_drop_wen", rf_wen_mc, 1'b0);
    chk("c_done_busy", mc_busy, 1'b1);
    tick();
    #1;
    chk("c_idle", mc_busy, 1'b0);
    chk("c_idle_wen", rf_wen_mc, 1'b0);
    tick();

    // Back-to-back issue on the DONE write cycle
    mc_issue = 1'b1; mc_dest = 5'd12; mc_lat = 4'd1;
    tick();
    mc_issue = 1'b0;
    tick();
    mc_issue = 1'b1; mc_dest = 5'd13; mc_lat = 4'd1;
    #1;
    chk("d_first_wen", rf_wen_mc, 1'b1);
    tick();
    mc_issue = 1'b0;
    dec_reg  = {5'd0, 5'd0, 5'd13};
    dec_ren  = 3'b001;
    #1;
    chk("d_second_busy", mc_busy, 1'b1);
    chk("d_second_stall", stall, 1'b1);
    tick();
    #1;
    chk("d_second_sel", psel(0), FWD_MC);
    chk("d_second_wen", rf_wen_mc, 1'b1);
    tick();
    #1;
    chk("d_idle", mc_busy, 1'b0);
    clear_in();
    tick();

    // Reset while BUSY with cnt=2 abandons the op
    mc_issue = 1'b1; mc_dest = 5'd20; mc_lat = 4'd4;
    tick();
    mc_issue = 1'b0;
    tick();
    RST = 1'b1;
    #1;
    chk("e_rst_wen", rf_wen_mc, 1'b0);
    tick();
    RST     = 1'b0;
    dec_reg = {5'd0, 5'd20, 5'd0};
    dec_ren = 3'b011;
    #1;
    chk("e_no_stall", stall, 1'b0);
    for (int unsigned k = 0; k < 6; k++) begin
      chk($sformatf("e_busy%0d", k), mc_busy, 1'b0);
      chk($sformatf("e_wen%0d", k), rf_wen_mc, 1'b0);
      chk($sformatf("e_r0sel%0d", k), psel(0), FWD_RF);
      chk($sformatf("e_r0data%0d", k), fwd_data[31:0], 32'h0);
      tick();
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
